crc_engine: RTL and testbench

CRC_ENGINE -- requirements
Module: crc_engine

---
 rtl/crc_engine.sv | 126 ++++++++++++
 tb/tb_crc_engine.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/crc_engine.sv
// Serial reflected CRC engine.
// It absorbs one frame bit per cycle into an LFSR. When the frame ends it does one of two things:
//   - generate mode: shifts the CRC out LSB first;
//   - check mode: reports whether the residue is zero.
module crc_engine #(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] POLY  = 8'hC4,
   parameter logic [WIDTH-1:0] SEED  = 8'hD8
) (
   input  logic clk,
   input  logic rst,
   input  logic data_in,
   input  logic active,
   input  logic check_mode,
   output logic crc_out,
   output logic crc_valid,
   output logic check_done,
   output logic crc_ok,
   output logic busy
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ABSORB    = 2'd1,
      SHIFT_OUT = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  lfsr, lfsr_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              mode_q, mode_d;
   logic              out_d, valid_d, done_d, ok_d;

   // One reflected LFSR step: the feedback is the outgoing bit XOR the incoming data bit.
   function automatic logic [WIDTH-1:0] absorb_bit(input logic [WIDTH-1:0] cur, input logic d);
      logic fb;
      fb = cur[0] ^ d;
      return (cur >> 1) ^ (fb ? POLY : '0);
   endfunction

   assign busy = (state_q != IDLE);

   // Next-state and next-output decode.
   // A frame start (from IDLE or aborting SHIFT_OUT) always absorbs into SEED.
   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      out_d   = crc_out;
      valid_d = crc_valid;
      done_d  = 1'b0;
      ok_d    = crc_ok;
      case (state_q)
         IDLE: begin
            if (active) begin
               lfsr_d  = absorb_bit(SEED, data_in);
               mode_d  = check_mode;
               state_d = ABSORB;
            end
         end
         ABSORB: begin
            if (active) begin
               lfsr_d = absorb_bit(lfsr, data_in);
            end else if (!mode_q) begin
               cnt_d   = '0;
               state_d = SHIFT_OUT;
            end else begin
               ok_d    = (lfsr == '0);
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         SHIFT_OUT: begin
            if (active) begin
               // A new frame aborts the remaining output bits.
               out_d   = 1'b0;
               valid_d = 1'b0;
               lfsr_d  = absorb_bit(SEED, data_in);
               mode_d  = check_mode;
               state_d = ABSORB;
            end else if (cnt_q == CW'(WIDTH)) begin
               out_d   = 1'b0;
               valid_d = 1'b0;
               state_d = IDLE;
            end else begin
               out_d   = lfsr[0];
               valid_d = 1'b1;
               lfsr_d  = lfsr >> 1;
               cnt_d   = cnt_q + CW'(1);
            end
         end
         default: begin
            out_d   = 1'b0;
            valid_d = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State, LFSR and registered outputs. Reset clears all of them immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         lfsr       <= SEED;
         cnt_q      <= '0;
         mode_q     <= 1'b0;
         crc_out    <= 1'b0;
         crc_valid  <= 1'b0;
         check_done <= 1'b0;
         crc_ok     <= 1'b0;
      end else begin
         state_q    <= state_d;
         lfsr       <= lfsr_d;
         cnt_q      <= cnt_d;
         mode_q     <= mode_d;
         crc_out    <= out_d;
         crc_valid  <= valid_d;
         check_done <= done_d;
         crc_ok     <= ok_d;
      end
   end

endmodule

// File: tb/tb_crc_engine.sv
// Scoreboard bench for crc_engine.
// Instance a uses the default 8-bit CRC; instance b uses the 16-bit A001/FFFF CRC.
module tb_crc_engine;

   logic clk = 1'b0;
   logic rst;
   logic a_data, a_active, a_mode, a_crc, a_valid, a_done, a_ok, a_busy;
   logic b_data, b_active, b_mode, b_crc, b_valid, b_done, b_ok, b_busy;

   int tests = 0;
   int fails = 0;

   logic qa_bit[$];
   logic qb_bit[$];
   logic qa_ok[$];
   logic qb_ok[$];

   crc_engine dut_a (
      .clk(clk), .rst(rst), .data_in(a_data), .active(a_active), .check_mode(a_mode),
      .crc_out(a_crc), .crc_valid(a_valid), .check_done(a_done), .crc_ok(a_ok), .busy(a_busy)
   );

   crc_engine #(.WIDTH(16), .POLY(16'hA001), .SEED(16'hFFFF)) dut_b (
      .clk(clk), .rst(rst), .data_in(b_data), .active(b_active), .check_mode(b_mode),
      .crc_out(b_crc), .crc_valid(b_valid), .check_done(b_done), .crc_ok(b_ok), .busy(b_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic extra(input string name, input logic act);
      tests++;
      fails++;
      $display("FAIL %s: got %0b with nothing expected", name, act);
   endtask

   // Monitor: pops the scoreboard whenever either DUT presents a CRC bit or a check result.
   always @(negedge clk) begin
      if (a_valid) begin
         if (qa_bit.size() == 0) extra("a_crc_bit", a_crc);
         else check("a_crc_bit", 32'(a_crc), 32'(qa_bit.pop_front()));
      end else begin
         check("a_crc_out_quiet", 32'(a_crc), 32'd0);
      end
      if (a_done) begin
         if (qa_ok.size() == 0) extra("a_crc_ok", a_ok);
         else check("a_crc_ok", 32'(a_ok), 32'(qa_ok.pop_front()));
      end
      if (b_valid) begin
         if (qb_bit.size() == 0) extra("b_crc_bit", b_crc);
         else check("b_crc_bit", 32'(b_crc), 32'(qb_bit.pop_front()));
      end
      if (b_done) begin
         if (qb_ok.size() == 0) extra("b_crc_ok", b_ok);
         else check("b_crc_ok", 32'(b_ok), 32'(qb_ok.pop_front()));
      end
   end

   // Drive n bits LSB first. check_mode is inverted after the first bit to show it is latched.
   task automatic run_frame(input int sel, input logic [31:0] bits, input int n, input logic mode);
      for (int i = 0; i < n; i++) begin
         if (sel == 0) begin
            a_active = 1'b1; a_data = bits[i]; a_mode = (i == 0) ? mode : ~mode;
         end else begin
            b_active = 1'b1; b_data = bits[i]; b_mode = (i == 0) ? mode : ~mode;
         end
         @(posedge clk); #1;
      end
      if (sel == 0) begin a_active = 1'b0; a_data = 1'b0; end
      else begin b_active = 1'b0; b_data = 1'b0; end
   endtask

   task automatic expect_crc(input int sel, input logic [31:0] value, input int n);
      for (int i = 0; i < n; i++) begin
         if (sel == 0) qa_bit.push_back(value[i]);
         else qb_bit.push_back(value[i]);
      end
   endtask

   task automatic wait_idle(input int sel, input string name);
      int k;
      k = 0;
      while (((sel == 0) ? a_busy : b_busy) && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      if (k >= 100) begin
         tests++;
         fails++;
         $display("FAIL %s_timeout: busy still 1 after %0d cycles, required 0", name, k);
      end
      @(negedge clk); #1;
      if (sel == 0) check({name, "_drained"}, 32'(qa_bit.size() + qa_ok.size()), 32'd0);
      else check({name, "_drained"}, 32'(qb_bit.size() + qb_ok.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      a_active = 1'b0; a_data = 1'b0; a_mode = 1'b0;
      b_active = 1'b0; b_data = 1'b0; b_mode = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 32'(a_valid), 32'd0);
      check("rst_done", 32'(a_done), 32'd0);
      check("rst_ok", 32'(a_ok), 32'd0);
      check("rst_busy", 32'(a_busy), 32'd0);
      check("rst_lfsr", 32'(dut_a.lfsr), 32'h0000_00D8);
      check("rst_lfsr_b", 32'(dut_b.lfsr), 32'h0000_FFFF);
      @(negedge clk) rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Zero byte generates 0x14.
      expect_crc(0, 32'h14, 8);
      run_frame(0, 32'h00, 8, 1'b0);
      check("busy_after_frame", 32'(a_busy), 32'd1);
      wait_idle(0, "gen_zero");

      // 0xFF generates 0x72.
      expect_crc(0, 32'h72, 8);
      run_frame(0, 32'hFF, 8, 1'b0);
      wait_idle(0, "gen_ff");

      // Back-to-back zero frames: the seed reloads each time.
      expect_crc(0, 32'h14, 8);
      run_frame(0, 32'h00, 8, 1'b0);
      wait_idle(0, "b2b_1");
      expect_crc(0, 32'h14, 8);
      run_frame(0, 32'h00, 8, 1'b0);
      wait_idle(0, "b2b_2");

      // Check mode: data followed by its CRC gives a zero residue.
      qa_ok.push_back(1'b1);
      run_frame(0, {16'h0, 8'h14, 8'h00}, 16, 1'b1);
      wait_idle(0, "chk_zero");
      repeat (3) @(posedge clk);
      #1;
      check("crc_ok_held", 32'(a_ok), 32'd1);

      qa_ok.push_back(1'b1);
      run_frame(0, {16'h0, 8'h72, 8'hFF}, 16, 1'b1);
      wait_idle(0, "chk_ff");

      // A single flipped bit, in the data or in the CRC, fails the check.
      qa_ok.push_back(1'b0);
      run_frame(0, {16'h0, 8'h14, 8'h04}, 16, 1'b1);
      wait_idle(0, "chk_flip_data");
      qa_ok.push_back(1'b0);
      run_frame(0, {16'h0, 8'h15, 8'h00}, 16, 1'b1);
      wait_idle(0, "chk_flip_crc");
      qa_ok.push_back(1'b1);
      run_frame(0, {16'h0, 8'h14, 8'h00}, 16, 1'b1);
      wait_idle(0, "chk_again");

      // Abort during the third output bit. The new frame still gives 0x14.
      expect_crc(0, 32'h04, 3);
      run_frame(0, 32'h00, 8, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      expect_crc(0, 32'h14, 8);
      run_frame(0, 32'h00, 8, 1'b0);
      wait_idle(0, "abort");

      // Reset during the fifth output bit truncates the output.
      expect_crc(0, 32'h04, 4);
      run_frame(0, 32'h00, 8, 1'b0);
      repeat (6) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("mid_rst_valid", 32'(a_valid), 32'd0);
      check("mid_rst_out", 32'(a_crc), 32'd0);
      check("mid_rst_ok", 32'(a_ok), 32'd0);
      check("mid_rst_busy", 32'(a_busy), 32'd0);
      check("mid_rst_lfsr", 32'(dut_a.lfsr), 32'h0000_00D8);
      @(negedge clk) rst = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      check("mid_rst_drained", 32'(qa_bit.size()), 32'd0);

      // 16-bit instance: byte 0x01 gives 0x807E, and the check loop closes.
      expect_crc(1, 32'h807E, 16);
      run_frame(1, 32'h01, 8, 1'b0);
      wait_idle(1, "b_gen");
      qb_ok.push_back(1'b1);
      run_frame(1, {8'h0, 16'h807E, 8'h01}, 24, 1'b1);
      wait_idle(1, "b_chk");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
